main_memory: RTL and testbench

Backing main memory that services the direct-mapped cache's miss traffic. It sits directly downstream of the cache and accepts one word request at a time on the cache's memory side (`read_en`, `memory_in` address, `memory_out` data). After reset it fills itself with a deterministic pattern, then answers each request after a fixed programmable latency. A write path is included so a later write-back cache can use the same block unchanged.

---
 rtl/main_memory_if.sv | 30 +++
 rtl/main_memory.sv | 140 ++++++++++++++
 tb/tb_main_memory.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/main_memory_if.sv
// Word-request bus between the cache's memory side and main_memory.
// mem_err exists only when MEM_RANGE_CHECK_EN is defined.
interface main_memory_if;
    logic        read_en;
    logic        write_en;
    logic [31:0] memory_in;
    logic [31:0] wr_data;
    logic [31:0] memory_out;
    logic        mem_valid;
    logic        mem_ready;
`ifdef MEM_RANGE_CHECK_EN
    logic        mem_err;
`endif

    modport master (
        output read_en, write_en, memory_in, wr_data,
`ifdef MEM_RANGE_CHECK_EN
        input  mem_err,
`endif
        input  memory_out, mem_valid, mem_ready
    );

    modport slave (
        input  read_en, write_en, memory_in, wr_data,
`ifdef MEM_RANGE_CHECK_EN
        output mem_err,
`endif
        output memory_out, mem_valid, mem_ready
    );
endinterface

// File: rtl/main_memory.sv
// Backing word memory: self-fills with A5A5_xxxx after reset, then serves one request per LATENCY cycles.
// Optional MEM_RANGE_CHECK_EN flags accesses with nonzero address bits above the array.
module main_memory #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    main_memory_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_q, init_d;
    logic [7:0]          lat_q, lat_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdat_q, wdat_d;
    logic                wr_q, wr_d;
    logic                oor_q, oor_d;
    logic [31:0]         out_q, out_d;
    logic                valid_q, valid_d;
`ifdef MEM_RANGE_CHECK_EN
    logic                err_q, err_d;
`endif

    logic [31:0]         mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [31:0]         mem_wd;
    logic [31:0]         init_ext;
    logic [31:0]         pattern;

    always_comb begin
        init_ext = 32'(init_q);
        pattern  = 32'hA5A5_0000 | {16'h0000, init_ext[15:0]};
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        out_d   = out_q;
        valid_d = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        err_d   = 1'b0;
`endif
        mem_we  = 1'b0;
        mem_wa  = init_q;
        mem_wd  = pattern;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                init_d = init_q + 1'b1;
                if (init_q == {ADDR_W{1'b1}}) state_d = IDLE;
            end
            IDLE: begin
                if (bus.read_en || bus.write_en) begin
                    idx_d   = bus.memory_in[ADDR_W+1:2];
                    wdat_d  = bus.wr_data;
                    // write wins when both enables are high
                    wr_d    = bus.write_en;
`ifdef MEM_RANGE_CHECK_EN
                    oor_d   = |bus.memory_in[31:ADDR_W+2];
`else
                    oor_d   = 1'b0;
`endif
                    lat_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (lat_q == 8'd0) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        mem_we = !oor_q;
                        mem_wa = idx_q;
                        mem_wd = wdat_q;
                    end else begin
                        out_d   = oor_q ? 32'hDEAD_BEEF : mem[idx_q];
                        valid_d = 1'b1;
                    end
`ifdef MEM_RANGE_CHECK_EN
                    err_d = oor_q;
`endif
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            init_q  <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            out_q   <= out_d;
            valid_q <= valid_d;
`ifdef MEM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Array is not reset: init rewrites every word after each reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.memory_out = out_q;
    assign bus.mem_valid  = valid_q;
    assign bus.mem_ready  = (state_q == IDLE);
`ifdef MEM_RANGE_CHECK_EN
    assign bus.mem_err    = err_q;
`endif
endmodule

// File: tb/tb_main_memory.sv
// Random + directed checks of main_memory against an array model and a fixed-latency timing rule.
module tb_main_memory;
    localparam int ADDR_W = 14;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic gclk   = 1'b0;
    logic grst_n = 1'b0;
    always #5 gclk = ~gclk;

    main_memory_if bus ();

    main_memory #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk (gclk),
        .rst (grst_n),
        .bus (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'hA5A5_0000 | 32'(i & 16'hFFFF);
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return |a[31:ADDR_W+2];
`else
        return 1'b0;
`endif
    endfunction

    task automatic bus_idle();
        bus.read_en   = 1'b0;
        bus.write_en  = 1'b0;
        bus.memory_in = '0;
        bus.wr_data   = '0;
    endtask

    // Release reset and count edges until mem_ready; outputs must stay quiet meanwhile.
    task automatic release_and_init();
        int n;
        logic noisy;
        n = 0;
        noisy = 1'b0;
        @(negedge gclk);
        grst_n = 1'b1;
        while (n < DEPTH + 100) begin
            @(posedge gclk); #1;
            n++;
            if (bus.mem_valid || bus.memory_out != 32'h0) noisy = 1'b1;
            if (bus.mem_ready) break;
        end
        chk("init_len", 32'(n), 32'(DEPTH));
        chk("init_quiet", {31'h0, noisy}, 32'h0);
        model_init();
    endtask

    // One request, checked edge by edge; BUSY inputs are scrambled.
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold, input string tag,
                       output logic [31:0] got);
        logic [ADDR_W-1:0] idx;
        bit                oor, is_rd;
        logic [31:0]       exp_d;
        idx   = addr[ADDR_W+1:2];
        oor   = out_of_range(addr);
        is_rd = rd && !wr;
        exp_d = oor ? 32'hDEAD_BEEF : model[idx];
        got   = 32'hx;
        @(negedge gclk);
        chk({tag, "_ready_pre"}, {31'h0, bus.mem_ready}, 32'h1);
        bus.read_en   = rd;
        bus.write_en  = wr;
        bus.memory_in = addr;
        bus.wr_data   = data;
        @(posedge gclk); #1;
        if (wr && !oor) model[idx] = data;
        for (int i = 1; i <= LAT + 1; i++) begin
            if (i <= LAT) begin
                bus.read_en   = 1'($urandom);
                bus.write_en  = 1'($urandom);
                bus.memory_in = $urandom;
                bus.wr_data   = $urandom;
            end else if (hold) begin
                bus.read_en   = rd;
                bus.write_en  = wr;
                bus.memory_in = addr;
                bus.wr_data   = data;
            end else begin
                bus_idle();
            end
            @(posedge gclk); #1;
            chk({tag, "_ready"}, {31'h0, bus.mem_ready},
                {31'h0, (i == LAT) || (i == LAT + 1 && !hold)});
            chk({tag, "_valid"}, {31'h0, bus.mem_valid}, {31'h0, (i == LAT) && is_rd});
`ifdef MEM_RANGE_CHECK_EN
            chk({tag, "_err"}, {31'h0, bus.mem_err}, {31'h0, (i == LAT) && oor});
`endif
            if (i == LAT && is_rd) begin
                got = bus.memory_out;
                chk({tag, "_data"}, bus.memory_out, exp_d);
            end
        end
        if (hold) begin
            bus_idle();
            for (int j = 1; j <= LAT; j++) begin
                @(posedge gclk); #1;
                chk({tag, "_rt_valid"}, {31'h0, bus.mem_valid}, {31'h0, (j == LAT) && is_rd});
                if (j == LAT) chk({tag, "_rt_data"}, bus.memory_out, exp_d);
            end
        end
    endtask

    initial begin
        logic [31:0] got, a;
        bit rd, wr;
        bus_idle();
        #2;
        chk("rst_out", bus.memory_out, 32'h0);
        chk("rst_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
`ifdef MEM_RANGE_CHECK_EN
        chk("rst_err", {31'h0, bus.mem_err}, 32'h0);
`endif
        release_and_init();

        req(1, 0, 32'h1461, 0, 0, "pat1461", got);
        chk("pat1461_const", got, 32'hA5A5_0518);
        req(1, 0, 32'hF634, 0, 0, "patF634", got);
        chk("patF634_const", got, 32'hA5A5_3D8D);
        req(0, 1, 32'h512D, 32'h1234_5678, 0, "wr512D", got);
        req(1, 0, 32'h512C, 0, 0, "rd512C", got);
        chk("rd512C_const", got, 32'h1234_5678);
        req(1, 0, 32'h8863, 0, 1, "retrig", got);

        // abort a read in flight
        @(negedge gclk);
        bus.read_en = 1'b1; bus.memory_in = 32'h1461;
        @(posedge gclk); #1;
        bus_idle();
        @(posedge gclk); #1;
        grst_n = 1'b0;
        #1;
        chk("abort_out", bus.memory_out, 32'h0);
        chk("abort_ready", {31'h0, bus.mem_ready}, 32'h0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge gclk); #1;
            chk("abort_valid", {31'h0, bus.mem_valid}, 32'h0);
        end
        release_and_init();
        req(1, 0, 32'h512D, 0, 0, "post_rst", got);
        chk("post_rst_const", got, 32'hA5A5_144B);

        req(1, 0, 32'h0001_0000, 0, 0, "range", got);
`ifdef MEM_RANGE_CHECK_EN
        chk("range_const", got, 32'hDEAD_BEEF);
        req(0, 1, 32'h0002_0010, 32'hCAFE_F00D, 0, "range_wr", got);
`else
        chk("range_const", got, 32'hA5A5_0000);
`endif
        req(1, 1, 32'h0000_0040, 32'h0BAD_CAFE, 0, "both", got);
        req(1, 0, 32'h0000_0040, 0, 0, "both_rd", got);
        chk("both_rd_const", got, 32'h0BAD_CAFE);

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom);
            wr = ($urandom_range(0, 9) < 4);
            if (!rd && !wr) rd = 1'b1;
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) << 2 : 32'($urandom_range(0, DEPTH - 1)) << 2;
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 7) == 0) a[31:ADDR_W+2] = 16'($urandom);
            req(rd, wr, a, $urandom, 0, "rand", got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
